// File: rtl/id_pkg.sv
// Shared constants and types for the ID-stage register hazard scoreboard.
// Index space is 2**IDX_W; only indices below NUM_REGS are tracked (PC_IDX never is).
package id_pkg;
   localparam int NUM_REGS = 15;
   localparam int IDX_W    = 4;
   localparam int CNT_W    = 2;
   localparam int PC_IDX   = 15;
   localparam int NUM_IDX  = 2 ** IDX_W;

   typedef logic [IDX_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      DONE
   } drain_state_t;
endpackage

// File: rtl/id_reg_scoreboard_sb_counter.sv
// sb_counter: per-register pending-write counter, saturating at 0 and at max.
// Latency: count updates on the next edge; zero/full/underflow are combinational.
// Backpressure: none here; the top prevents increments while full via its stall.
module sb_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero,
   output logic         full,
   output logic         underflow
);
   logic up;
   logic down;

   assign zero      = (cnt == '0);
   assign full      = &cnt;
   assign underflow = dec && zero;

   // A decrement on an empty counter is dropped, so inc+dec at zero still nets +1.
   assign up   = inc && (!full || dec);
   assign down = dec && !zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (up && !down) begin
         cnt <= cnt + W'(1);
      end else if (!up && down) begin
         cnt <= cnt - W'(1);
      end
   end
endmodule

// File: rtl/id_reg_scoreboard.sv
// Register hazard scoreboard: counts in-flight writes, stalls issue on pending sources or drain.
// Latency: stall is same-cycle combinational; counters and drain FSM update next edge.
// Backpressure: stall holds IF/ID while any source is pending, dest counter is full, or draining.
module id_reg_scoreboard
   import id_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic [IDX_W-1:0] issue_src1,
   input  logic [IDX_W-1:0] issue_src2,
   input  logic             issue_two_src,
   input  logic             issue_wb_en,
   input  logic [IDX_W-1:0] issue_dest,
   input  logic             wb_en,
   input  logic [IDX_W-1:0] wb_dest,
   input  logic             drain_req,
   output logic             stall,
   output logic             drain_done,
   output logic             busy,
   output logic             err_underflow
);
   logic [NUM_IDX-1:0] nz;
   logic [NUM_IDX-1:0] full;
   logic [NUM_IDX-1:0] uf;
   logic [NUM_IDX-1:0] hz;
   logic               accept;
   logic               hz1;
   logic               hz2;
   logic               ovf;
   drain_state_t       state;
   drain_state_t       state_nxt;

   for (genvar r = 0; r < NUM_IDX; r++) begin : g_reg
      if (r < NUM_REGS) begin : g_trk
         logic             inc;
         logic             dec;
         logic             zero;
         logic [CNT_W-1:0] cnt;

         assign inc = accept && issue_wb_en && (issue_dest == IDX_W'(r));
         assign dec = wb_en && (wb_dest == IDX_W'(r));

         sb_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc),
            .dec       (dec),
            .cnt       (cnt),
            .zero      (zero),
            .full      (full[r]),
            .underflow (uf[r])
         );

         assign nz[r] = !zero;
         // Effective count is non-zero unless a same-cycle write-back retires the last write.
         assign hz[r] = !zero && !(dec && cnt == CNT_W'(1));
      end else begin : g_untrk
         assign nz[r]   = 1'b0;
         assign full[r] = 1'b0;
         assign uf[r]   = 1'b0;
         assign hz[r]   = 1'b0;
      end
   end

   assign hz1    = hz[issue_src1];
   assign hz2    = issue_two_src && hz[issue_src2];
   assign ovf    = issue_wb_en && full[issue_dest];
   assign stall  = issue_valid && (hz1 || hz2 || ovf || state != IDLE);
   assign accept = issue_valid && !stall;
   assign busy   = |nz;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_underflow <= 1'b0;
      end else if (|uf) begin
         err_underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      drain_done = 1'b0;
      case (state)
         IDLE:  if (drain_req) state_nxt = DRAIN;
         DRAIN: if (~|hz) state_nxt = DONE;
         DONE: begin
            drain_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_id_reg_scoreboard.sv
// Directed bench for id_reg_scoreboard: linear steps with hand-computed expectations.
module tb_id_reg_scoreboard;
   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid;
   logic [3:0] issue_src1;
   logic [3:0] issue_src2;
   logic       issue_two_src;
   logic       issue_wb_en;
   logic [3:0] issue_dest;
   logic       wb_en;
   logic [3:0] wb_dest;
   logic       drain_req;
   logic       stall;
   logic       drain_done;
   logic       busy;
   logic       err_underflow;

   int n_cmp = 0;
   int n_err = 0;

   id_reg_scoreboard dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issue_valid),
      .issue_src1    (issue_src1),
      .issue_src2    (issue_src2),
      .issue_two_src (issue_two_src),
      .issue_wb_en   (issue_wb_en),
      .issue_dest    (issue_dest),
      .wb_en         (wb_en),
      .wb_dest       (wb_dest),
      .drain_req     (drain_req),
      .stall         (stall),
      .drain_done    (drain_done),
      .busy          (busy),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic issue(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic we, input logic [3:0] d);
      issue_valid   = v;
      issue_src1    = s1;
      issue_src2    = s2;
      issue_two_src = two;
      issue_wb_en   = we;
      issue_dest    = d;
   endtask

   task automatic wb(input logic en, input logic [3:0] d);
      wb_en   = en;
      wb_dest = d;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drain_req = 1'b0;
      issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      wb(1'b0, 4'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // 1: reset state
      chk("rst_stall", stall, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drain_done", drain_done, 1'b0);
      chk("rst_err", err_underflow, 1'b0);

      // 2: RAW on R3 resolved by same-cycle write-back
      issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3);
      settle();
      chk("raw_issue_dest", stall, 1'b0);
      tick();
      chk("raw_busy", busy, 1'b1);
      issue(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 4'd0);
      settle();
      chk("raw_stall0", stall, 1'b1);
      tick();
      chk("raw_stall1", stall, 1'b1);
      wb(1'b1, 4'd3);
      settle();
      chk("raw_wb_lifts", stall, 1'b0);
      tick();
      issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      wb(1'b0, 4'd0);
      settle();
      chk("raw_cnt_zero", busy, 1'b0);

      // 3: overflow on R5 at three in flight
      issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk($sformatf("ovf_fill%0d", i), stall, 1'b0);
         tick();
      end
      chk("ovf_stall", stall, 1'b1);
      wb(1'b1, 4'd5);
      settle();
      chk("ovf_wb_no_lift", stall, 1'b1);
      tick();
      wb(1'b0, 4'd0);
      settle();
      chk("ovf_accept_next", stall, 1'b0);
      tick();
      issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5);
      settle();
      chk("ovf_full_again", stall, 1'b1);
      issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      wb(1'b1, 4'd5);
      tick();
      tick();
      chk("ovf_draining_busy", busy, 1'b1);
      tick();
      wb(1'b0, 4'd0);
      settle();
      chk("ovf_empty", busy, 1'b0);

      // 4: index 15 is untracked
      issue(1'b1, 4'd15, 4'd15, 1'b1, 1'b1, 4'd15);
      wb(1'b1, 4'd15);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk($sformatf("pc_stall%0d", i), stall, 1'b0);
         tick();
      end
      issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      wb(1'b0, 4'd0);
      settle();
      chk("pc_busy", busy, 1'b0);
      chk("pc_no_uf", err_underflow, 1'b0);

      // 5: write-back to idle R7 is an underflow
      wb(1'b1, 4'd7);
      tick();
      wb(1'b0, 4'd0);
      chk("uf_set", err_underflow, 1'b1);
      chk("uf_busy", busy, 1'b0);
      issue(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 4'd0);
      settle();
      chk("uf_r7_no_hazard", stall, 1'b0);
      issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      tick();
      tick();
      chk("uf_sticky", err_underflow, 1'b1);

      // 6: drain with R1 and R2 pending
      issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1);
      tick();
      issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2);
      tick();
      issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      drain_req = 1'b1;
      tick();
      issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4);
      settle();
      chk("drn_stall_a", stall, 1'b1);
      chk("drn_no_pulse_a", drain_done, 1'b0);
      wb(1'b1, 4'd1);
      tick();
      chk("drn_stall_b", stall, 1'b1);
      chk("drn_no_pulse_b", drain_done, 1'b0);
      wb(1'b1, 4'd2);
      settle();
      chk("drn_stall_c", stall, 1'b1);
      tick();
      wb(1'b0, 4'd0);
      drain_req = 1'b0;
      settle();
      chk("drn_pulse", drain_done, 1'b1);
      chk("drn_stall_done", stall, 1'b1);
      chk("drn_busy_done", busy, 1'b0);
      issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      tick();
      chk("drn_pulse_one", drain_done, 1'b0);
      chk("drn_idle_busy", busy, 1'b0);

      // drain with nothing pending: one DRAIN cycle then DONE
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      chk("drn0_in_drain", drain_done, 1'b0);
      tick();
      chk("drn0_pulse", drain_done, 1'b1);
      tick();
      chk("drn0_pulse_end", drain_done, 1'b0);

      // reset mid-drain: no pulse, underflow flag cleared
      issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1);
      tick();
      issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      drain_req = 1'b1;
      tick();
      rst = 1'b1;
      drain_req = 1'b0;
      tick();
      rst = 1'b0;
      chk("rstd_no_pulse0", drain_done, 1'b0);
      chk("rstd_busy", busy, 1'b0);
      chk("rstd_err_clr", err_underflow, 1'b0);
      tick();
      chk("rstd_no_pulse1", drain_done, 1'b0);
      issue(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 4'd0);
      settle();
      chk("rstd_idle_accept", stall, 1'b0);
      issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
